// File: rtl/mixer_pkg.sv
// Shared state encoding, accumulator sizing and AGC constants for track_mixer.
// No timing or flow-control content of its own.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    GAIN
  } mixer_state_t;

  localparam logic [8:0] AGC_UNITY   = 9'd256;
  localparam logic [8:0] AGC_ATTACK  = 9'd16;
  localparam logic [8:0] AGC_FLOOR   = 9'd32;
  localparam int         AGC_RELEASE = 64;

  // Signed width that holds NUM_INPUTS full-scale magnitudes of either sign.
  function automatic int accWidth(input int num_inputs, input int mag_w);
    return mag_w + 1 + $clog2(num_inputs);
  endfunction

endpackage

// File: rtl/mixer_saturate.sv
// Per-output |acc| >> MIX_SHIFT, optional gain (MIXER_AGC_EN), saturate to MAG_W, sign without negative zero.
// Purely combinational, zero latency; no flow control.
module mixer_saturate #(
  parameter int ACC_W     = 11,
  parameter int MAG_W     = 8,
  parameter int MIX_SHIFT = 1
) (
  input  logic signed [ACC_W-1:0] acc,
`ifdef MIXER_AGC_EN
  input  logic [8:0]              gain,
  output logic                    clip_pre,
`endif
  output logic [MAG_W-1:0]        mag,
  output logic                    sign,
  output logic                    clip
);

  localparam logic [ACC_W-1:0] MAX_W = ACC_W'({MAG_W{1'b1}});

  logic             neg;
  logic [ACC_W-1:0] abs_v;
  logic [ACC_W-1:0] scaled;
  logic [ACC_W-1:0] res_w;
`ifdef MIXER_AGC_EN
  logic [ACC_W+8:0] prod;
`endif

  always_comb begin
    neg    = acc[ACC_W-1];
    abs_v  = neg ? $unsigned(-acc) : $unsigned(acc);
    // Shifting the magnitude rather than acc keeps rounding symmetric about zero.
    scaled = abs_v >> MIX_SHIFT;
`ifdef MIXER_AGC_EN
    prod     = {9'd0, scaled} * {{ACC_W{1'b0}}, gain};
    res_w    = ACC_W'(prod >> 8);
    clip_pre = (scaled > MAX_W);
`else
    res_w    = scaled;
`endif
    clip = (res_w > MAX_W);
    mag  = clip ? {MAG_W{1'b1}} : res_w[MAG_W-1:0];
    sign = neg && (res_w != '0);
  end

endmodule

// File: rtl/track_mixer.sv
// N-track to M-output time-multiplexed mixer with scale/saturate; MIXER_AGC_EN adds per-output gain.
// Strobe at edge k -> outValid at k+NUM_INPUTS+2 (k+NUM_INPUTS+3 with MIXER_AGC_EN); strobes while busy are dropped and flagged in overrun.
module track_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int MAG_W       = 8,
  parameter int MIX_SHIFT   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sampleStrobe,
  input  logic [NUM_INPUTS-1:0]                  sign,
  input  logic [NUM_INPUTS-1:0][MAG_W-1:0]       magnitude,
  input  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] routeMask,
  input  logic                                   clearOverrun,
  output logic [NUM_OUTPUTS-1:0]                 outSign,
  output logic [NUM_OUTPUTS-1:0][MAG_W-1:0]      outMagnitude,
  output logic                                   outValid,
  output logic [NUM_OUTPUTS-1:0]                 saturated,
  output logic                                   overrun
);

  localparam int ACC_W = accWidth(NUM_INPUTS, MAG_W);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
`ifdef MIXER_AGC_EN
  localparam mixer_state_t CAP_STATE = GAIN;
`else
  localparam mixer_state_t CAP_STATE = SCALE;
`endif

  mixer_state_t state, state_nxt;

  logic [IDX_W-1:0]                       idx;
  logic [NUM_INPUTS-1:0]                  snap_sign;
  logic [NUM_INPUTS-1:0][MAG_W-1:0]       snap_mag;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] snap_mask;
  logic signed [ACC_W-1:0]                acc [NUM_OUTPUTS];
  logic signed [ACC_W-1:0]                term;

  logic [NUM_OUTPUTS-1:0]                 res_sign, res_clip;
  logic [NUM_OUTPUTS-1:0][MAG_W-1:0]      res_mag;
  logic [NUM_OUTPUTS-1:0]                 stg_sign, stg_sat;
  logic [NUM_OUTPUTS-1:0][MAG_W-1:0]      stg_mag;
  logic                                   pend;

`ifdef MIXER_AGC_EN
  logic [8:0]             gain    [NUM_OUTPUTS];
  logic [5:0]             rel_cnt [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] clip_pre;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sampleStrobe) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_nxt = SCALE;
      SCALE: begin
`ifdef MIXER_AGC_EN
        state_nxt = GAIN;
`else
        state_nxt = IDLE;
`endif
      end
      GAIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    term = ACC_W'({1'b0, snap_mag[idx]});
    if (snap_sign[idx]) term = -term;
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_sat
    mixer_saturate #(
      .ACC_W     (ACC_W),
      .MAG_W     (MAG_W),
      .MIX_SHIFT (MIX_SHIFT)
    ) u_sat (
      .acc      (acc[o]),
`ifdef MIXER_AGC_EN
      .gain     (gain[o]),
      .clip_pre (clip_pre[o]),
`endif
      .mag      (res_mag[o]),
      .sign     (res_sign[o]),
      .clip     (res_clip[o])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      snap_sign    <= '0;
      snap_mag     <= '0;
      snap_mask    <= '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) acc[o] <= '0;
      stg_sign     <= '0;
      stg_mag      <= '0;
      stg_sat      <= '0;
      pend         <= 1'b0;
      outSign      <= '0;
      outMagnitude <= '0;
      saturated    <= '0;
      outValid     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      outValid <= pend;
      pend     <= (state == CAP_STATE);
      if (state == IDLE && sampleStrobe) begin
        snap_sign <= sign;
        snap_mag  <= magnitude;
        snap_mask <= routeMask;
        idx       <= '0;
      end
      if (state == ACCUM) begin
        idx <= idx + 1'b1;
        for (int o = 0; o < NUM_OUTPUTS; o++)
          if (snap_mask[o][idx]) acc[o] <= acc[o] + term;
      end
      // Results are staged so acc can be cleared while the outputs register one edge later.
      if (state == CAP_STATE) begin
        stg_sign <= res_sign;
        stg_mag  <= res_mag;
        stg_sat  <= res_clip;
        for (int o = 0; o < NUM_OUTPUTS; o++) acc[o] <= '0;
      end
      if (pend) begin
        outSign      <= stg_sign;
        outMagnitude <= stg_mag;
        saturated    <= stg_sat;
      end
      if (sampleStrobe && state != IDLE) overrun <= 1'b1;
      else if (clearOverrun)             overrun <= 1'b0;
    end
  end

`ifdef MIXER_AGC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        gain[o]    <= AGC_UNITY;
        rel_cnt[o] <= '0;
      end
    end else if (state == GAIN) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (clip_pre[o]) begin
          gain[o]    <= (gain[o] >= AGC_FLOOR + AGC_ATTACK) ? gain[o] - AGC_ATTACK : AGC_FLOOR;
          rel_cnt[o] <= '0;
        end else if (rel_cnt[o] == 6'(AGC_RELEASE - 1)) begin
          rel_cnt[o] <= '0;
          if (gain[o] < AGC_UNITY) gain[o] <= gain[o] + 1'b1;
        end else begin
          rel_cnt[o] <= rel_cnt[o] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_track_mixer.sv
// Scoreboard bench for track_mixer in its default configuration (4 tracks, 4 outputs, 8-bit, shift 1).
`timescale 1ns/1ps
module tb_track_mixer;

  typedef struct packed {
    logic [3:0]      sgn;
    logic [3:0][7:0] mag;
    logic [3:0]      sat;
    int              due;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            sampleStrobe;
  logic [3:0]      sign;
  logic [3:0][7:0] magnitude;
  logic [3:0][3:0] routeMask;
  logic            clearOverrun;
  logic [3:0]      outSign;
  logic [3:0][7:0] outMagnitude;
  logic            outValid;
  logic [3:0]      saturated;
  logic            overrun;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  exp_t exp_q[$];

  track_mixer #(
    .NUM_INPUTS  (4),
    .NUM_OUTPUTS (4),
    .MAG_W       (8),
    .MIX_SHIFT   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sampleStrobe (sampleStrobe),
    .sign         (sign),
    .magnitude    (magnitude),
    .routeMask    (routeMask),
    .clearOverrun (clearOverrun),
    .outSign      (outSign),
    .outMagnitude (outMagnitude),
    .outValid     (outValid),
    .saturated    (saturated),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] s, input logic [3:0][7:0] m, input logic [3:0][3:0] mk);
    exp_t r;
    int   sum;
    int   a;
    r = '0;
    for (int o = 0; o < 4; o++) begin
      sum = 0;
      for (int i = 0; i < 4; i++)
        if (mk[o][i]) sum += s[i] ? -int'(m[i]) : int'(m[i]);
      a = (sum < 0 ? -sum : sum) / 2;
      r.sat[o] = (a > 255);
      r.mag[o] = (a > 255) ? 8'd255 : 8'(a);
      r.sgn[o] = (sum < 0) && (a != 0);
    end
    return r;
  endfunction

  // Scoreboard: every outValid must match the oldest pending strobe, on its due edge.
  always @(negedge clk) begin
    if (!reset && outValid) begin
      exp_t e;
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_outvalid cyc=%0d got mag=%h sign=%b", cyc, outMagnitude, outSign);
      end else begin
        e = exp_q.pop_front();
        if (outSign !== e.sgn || outMagnitude !== e.mag || saturated !== e.sat || cyc != e.due) begin
          n_fail++;
          $display("FAIL out_check got sign=%b mag=%h sat=%b cyc=%0d, want sign=%b mag=%h sat=%b cyc=%0d",
                   outSign, outMagnitude, saturated, cyc, e.sgn, e.mag, e.sat, e.due);
        end
      end
    end
  end

  task automatic do_strobe(input bit accept);
    exp_t e;
    sampleStrobe = 1'b1;
    if (accept) begin
      e     = model(sign, magnitude, routeMask);
      e.due = cyc + 1 + 6;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    sampleStrobe = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_case1();
    sign      = 4'b0010;
    magnitude = {8'd0, 8'd0, 8'd50, 8'd200};
    routeMask = {4'b0000, 4'b0010, 4'b0001, 4'b0011};
  endtask

  task automatic set_case2();
    sign      = 4'b0000;
    magnitude = {8'd255, 8'd255, 8'd255, 8'd255};
    routeMask = {4'b1000, 4'b0111, 4'b1111, 4'b0001};
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (outValid !== 1'b0 || outMagnitude !== '0 || outSign !== '0 || saturated !== '0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b mag=%h sign=%b sat=%b ovr=%b, want all zero",
               outValid, outMagnitude, outSign, saturated, overrun);
    end
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_mix_basic();
    int v;
    set_case1();
    v = n_valid;
    do_strobe(1'b1);
    wait_cycles(8);
    n_checks++;
    if (outMagnitude[0] !== 8'd75 || outSign[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_out0 got mag=%0d sign=%b, want mag=75 sign=0", outMagnitude[0], outSign[0]);
    end
    n_checks++;
    if (n_valid != v + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_valid_count got %0d pending=%0d, want 1 pending=0", n_valid - v, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    set_case2();
    do_strobe(1'b1);
    wait_cycles(8);
    n_checks++;
    if (outMagnitude[1] !== 8'd255 || saturated[1] !== 1'b1 || saturated[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate got mag1=%0d sat=%b, want mag1=255 sat[1]=1 sat[0]=0", outMagnitude[1], saturated);
    end
  endtask

  task automatic test_cancel_empty();
    sign      = 4'b0101;
    magnitude = {8'd100, 8'd100, 8'd3, 8'd1};
    routeMask = {4'b0000, 4'b1100, 4'b0100, 4'b0001};
    do_strobe(1'b1);
    wait_cycles(8);
    n_checks++;
    if (outMagnitude[2] !== 8'd0 || outSign[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel got mag2=%0d sign2=%b, want 0 0", outMagnitude[2], outSign[2]);
    end
    n_checks++;
    if (outMagnitude[3] !== 8'd0 || outSign[3] !== 1'b0 || saturated[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_mask got mag3=%0d sign3=%b sat3=%b, want 0 0 0", outMagnitude[3], outSign[3], saturated[3]);
    end
    n_checks++;
    if (outMagnitude[0] !== 8'd0 || outSign[0] !== 1'b0 || outMagnitude[1] !== 8'd50 || outSign[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_zero got mag0=%0d sign0=%b mag1=%0d sign1=%b, want 0 0 50 1",
               outMagnitude[0], outSign[0], outMagnitude[1], outSign[1]);
    end
  endtask

  task automatic test_overrun();
    int v;
    set_case1();
    v = n_valid;
    do_strobe(1'b1);
    wait_cycles(1);
    sign         = 4'b1111;
    magnitude    = {8'd9, 8'd9, 8'd9, 8'd9};
    routeMask    = '1;
    sampleStrobe = 1'b1;
    wait_cycles(1);
    sampleStrobe = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set got %b, want 1", overrun);
    end
    wait_cycles(8);
    n_checks++;
    if (n_valid != v + 1 || exp_q.size() != 0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_hold got valids=%0d pending=%0d ovr=%b, want 1 0 1", n_valid - v, exp_q.size(), overrun);
    end
    clearOverrun = 1'b1;
    wait_cycles(1);
    clearOverrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear got %b, want 0", overrun);
    end
    do_strobe(1'b1);
    sampleStrobe = 1'b1;
    clearOverrun = 1'b1;
    wait_cycles(1);
    sampleStrobe = 1'b0;
    clearOverrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins got %b, want 1", overrun);
    end
    wait_cycles(8);
    clearOverrun = 1'b1;
    wait_cycles(1);
    clearOverrun = 1'b0;
  endtask

  task automatic test_reset_midaccum();
    int v;
    set_case1();
    do_strobe(1'b1);
    wait_cycles(1);
    reset = 1'b1;
    #1;
    n_checks++;
    if (outMagnitude !== '0 || outSign !== '0 || saturated !== '0 || overrun !== 1'b0 || outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state got mag=%h sign=%b sat=%b ovr=%b v=%b, want all zero",
               outMagnitude, outSign, saturated, overrun, outValid);
    end
    exp_q.delete();
    v = n_valid;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(10);
    n_checks++;
    if (n_valid != v) begin
      n_fail++;
      $display("FAIL midreset_no_valid got %0d pulses, want 0", n_valid - v);
    end
    set_case2();
    do_strobe(1'b1);
    wait_cycles(8);
    n_checks++;
    if (n_valid != v + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_recover got %0d pulses pending=%0d, want 1 0", n_valid - v, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int v;
    v = n_valid;
    for (int n = 0; n < 16; n++) begin
      sign      = 4'($urandom);
      magnitude = $urandom;
      routeMask = 16'($urandom);
      do_strobe(1'b1);
      for (int j = 0; j < 5; j++) begin
        sign      = 4'($urandom);
        magnitude = $urandom;
        routeMask = 16'($urandom);
        wait_cycles(1);
      end
    end
    wait_cycles(8);
    n_checks++;
    if (n_valid != v + 16 || exp_q.size() != 0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back got %0d pulses pending=%0d ovr=%b, want 16 0 0", n_valid - v, exp_q.size(), overrun);
    end
  endtask

  initial begin
    reset        = 1'b1;
    sampleStrobe = 1'b0;
    clearOverrun = 1'b0;
    sign         = '0;
    magnitude    = '0;
    routeMask    = '0;
    test_reset();
    test_mix_basic();
    test_saturate();
    test_cancel_empty();
    test_overrun();
    test_reset_midaccum();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
